// File: rtl/btb_update_ctrl.sv
// Purpose: write-side controller for the BTB arrays (tag/target/valid/2-bit counter); queues
//          resolved branches and applies each one as a read-modify-write.
// Latency: a record pushed at edge N is read in cycle N+1 and written at the edge ending cycle N+2.
// Backpressure: upd_ready = FIFO not full; the drain rate is one record per two cycles.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   upd_valid/upd_ready           resolved-branch handshake, with upd_pc, upd_target, upd_taken
//   btb_rindex, btb_windex        read and write index shared by all arrays
//   btb_load                      array write enable
//   tag_dout/valid_dout/cnt_dout  array read data for btb_rindex
//   tag_din/target_din/valid_din/cnt_din  array write data; all zero while btb_load is low
//   busy                          records queued or a write in progress

// Generic synchronous FIFO with an occupancy count.
// Latency: a pushed word is visible at pop_dat in the next cycle.
// Backpressure: push is ignored when full and pop is ignored when empty.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PONE = PW'(1);
    localparam logic [CW-1:0] CONE = CW'(1);
    localparam logic [CW-1:0] CMAX = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CMAX);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // Storage is cleared so the head index reads as 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CONE;
                2'b01:   count <= count - CONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module btb_update_ctrl #(
    parameter int width     = 32,
    parameter int bit_entry = 5,
    parameter int qdepth    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [width-1:0]          upd_pc,
    input  logic [width-1:0]          upd_target,
    input  logic                      upd_taken,
    output logic [bit_entry-1:0]      btb_rindex,
    output logic [bit_entry-1:0]      btb_windex,
    output logic                      btb_load,
    input  logic [width-bit_entry-3:0] tag_dout,
    input  logic                      valid_dout,
    input  logic [1:0]                cnt_dout,
    output logic [width-bit_entry-3:0] tag_din,
    output logic [width-1:0]          target_din,
    output logic                      valid_din,
    output logic [1:0]                cnt_din,
    output logic                      busy
);
    localparam int tw = width - bit_entry - 2;
    localparam int cw = $clog2(qdepth + 1);

    typedef struct packed {
        logic [width-1:0] pc;
        logic [width-1:0] target;
        logic             taken;
    } upd_t;

    typedef enum logic {
        S_READ  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nx;
    upd_t                 in_rec;
    upd_t                 head;
    logic                 q_full;
    logic                 q_empty;
    logic [cw-1:0]        q_count;
    logic                 q_push;
    logic                 q_pop;
    logic [bit_entry-1:0] head_index;
    logic [tw-1:0]        head_tag;
    logic                 hit_q;
    logic [1:0]           cnt_q;
    logic                 wr_en;
    logic [1:0]           cnt_nx;
    logic                 unused_pc_lsb;

    assign in_rec.pc     = upd_pc;
    assign in_rec.target = upd_target;
    assign in_rec.taken  = upd_taken;

    assign upd_ready = ~q_full;
    assign q_push    = upd_valid & upd_ready;

    fifo #(
        .W     ($bits(upd_t)),
        .DEPTH (qdepth)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_dat (in_rec),
        .pop      (q_pop),
        .pop_dat  (head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    assign head_index    = head.pc[bit_entry+1:2];
    assign head_tag      = head.pc[width-1:bit_entry+2];
    assign unused_pc_lsb = &{1'b0, head.pc[1:0]};

    // Both ports always point at the head entry; the arrays forward din on a
    // matching index, which is why S_WRITE works only from the captured values.
    assign btb_rindex = head_index;
    assign btb_windex = head_index;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_READ;
            hit_q <= 1'b0;
            cnt_q <= 2'b00;
        end else begin
            state <= state_nx;
            if (state == S_READ && !q_empty) begin
                hit_q <= valid_dout & (tag_dout == head_tag);
                cnt_q <= cnt_dout;
            end
        end
    end

    always_comb begin
        state_nx = state;
        q_pop    = 1'b0;
        wr_en    = 1'b0;
        cnt_nx   = 2'b00;
        case (state)
            S_READ: begin
                if (!q_empty) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nx = S_READ;
                q_pop    = 1'b1;
                if (hit_q) begin
                    wr_en = 1'b1;
                    if (head.taken) begin
                        cnt_nx = (cnt_q == 2'b11) ? 2'b11 : cnt_q + 2'b01;
                    end else begin
                        cnt_nx = (cnt_q == 2'b00) ? 2'b00 : cnt_q - 2'b01;
                    end
                end else if (head.taken) begin
                    // Allocate on a taken miss, starting weakly taken.
                    wr_en  = 1'b1;
                    cnt_nx = 2'b10;
                end
            end
            default: state_nx = S_READ;
        endcase
    end

    // Reset kills the write of an in-flight S_WRITE within the same cycle.
    assign btb_load   = wr_en & ~rst;
    assign tag_din    = btb_load ? head_tag    : '0;
    assign target_din = btb_load ? head.target : '0;
    assign valid_din  = btb_load;
    assign cnt_din    = btb_load ? cnt_nx      : 2'b00;

    assign busy = (q_count != '0) | (state == S_WRITE);
endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;
    localparam int W  = 32;
    localparam int BE = 5;
    localparam int QD = 4;
    localparam int TW = W - BE - 2;
    localparam int N  = 1 << BE;
    localparam int NV = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          upd_valid;
    logic          upd_ready;
    logic [W-1:0]  upd_pc;
    logic [W-1:0]  upd_target;
    logic          upd_taken;
    logic [BE-1:0] btb_rindex;
    logic [BE-1:0] btb_windex;
    logic          btb_load;
    logic [TW-1:0] tag_dout;
    logic          valid_dout;
    logic [1:0]    cnt_dout;
    logic [TW-1:0] tag_din;
    logic [W-1:0]  target_din;
    logic          valid_din;
    logic [1:0]    cnt_din;
    logic          busy;

    always #5 clk = ~clk;

    btb_update_ctrl #(.width(W), .bit_entry(BE), .qdepth(QD)) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .btb_rindex (btb_rindex),
        .btb_windex (btb_windex),
        .btb_load   (btb_load),
        .tag_dout   (tag_dout),
        .valid_dout (valid_dout),
        .cnt_dout   (cnt_dout),
        .tag_din    (tag_din),
        .target_din (target_din),
        .valid_din  (valid_din),
        .cnt_din    (cnt_din),
        .busy       (busy)
    );

    // Behavioural BTB arrays: asynchronous read, write on the clock edge.
    logic [TW-1:0] m_tag [N];
    logic [W-1:0]  m_tgt [N];
    logic          m_vld [N];
    logic [1:0]    m_cnt [N];
    logic          clr;

    assign tag_dout   = m_tag[btb_rindex];
    assign valid_dout = m_vld[btb_rindex];
    assign cnt_dout   = m_cnt[btb_rindex];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                m_tag[i] <= '0;
                m_tgt[i] <= '0;
                m_vld[i] <= 1'b0;
                m_cnt[i] <= 2'b00;
            end
        end else if (btb_load) begin
            m_tag[btb_windex] <= tag_din;
            m_tgt[btb_windex] <= target_din;
            m_vld[btb_windex] <= valid_din;
            m_cnt[btb_windex] <= cnt_din;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0]  pc;
        logic [W-1:0]  tgt;
        logic          tk;
        logic          ld;
        logic [BE-1:0] wi;
        logic [TW-1:0] tag;
        logic [W-1:0]  etgt;
        logic          vld;
        logic [1:0]    cnt;
    } vec_t;

    function automatic vec_t mk(input logic [W-1:0] pc, input logic [W-1:0] tgt, input logic tk,
                                input logic ld, input logic [BE-1:0] wi, input logic [TW-1:0] tag,
                                input logic [W-1:0] etgt, input logic vld, input logic [1:0] cnt);
        vec_t r;
        r.pc = pc; r.tgt = tgt; r.tk = tk; r.ld = ld; r.wi = wi;
        r.tag = tag; r.etgt = etgt; r.vld = vld; r.cnt = cnt;
        return r;
    endfunction

    vec_t v [NV];

    // Scoreboard for the streaming (backpressure) phase.
    typedef struct {
        logic [BE-1:0] wi;
        logic [TW-1:0] tag;
        logic [W-1:0]  tgt;
    } bp_t;

    bp_t  exp_q [$];
    bp_t  e;
    logic mon_en  = 1'b0;
    logic prev_ld = 1'b0;
    int   wr_cnt  = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (btb_load) begin
                chk("bp_load_gap", 64'(prev_ld), 64'(0));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bp_extra_write got windex 0x%0h want no write", btb_windex);
                end else begin
                    e = exp_q.pop_front();
                    chk("bp_windex", 64'(btb_windex), 64'(e.wi));
                    chk("bp_tag", 64'(tag_din), 64'(e.tag));
                    chk("bp_target", 64'(target_din), 64'(e.tgt));
                    chk("bp_cnt", 64'(cnt_din), 64'(2'b10));
                end
                wr_cnt++;
            end
            prev_ld = btb_load;
        end
    end

    int acc;
    int first_low;
    int kk;
    int nload;

    initial begin
        // Fresh BTB, then a single record at a time through the table.
        v[0]  = mk(32'h84, 32'h200, 1'b1, 1'b1, 5'd1, 25'h1, 32'h200, 1'b1, 2'b10);
        v[1]  = mk(32'h84, 32'h200, 1'b1, 1'b1, 5'd1, 25'h1, 32'h200, 1'b1, 2'b11);
        v[2]  = mk(32'h84, 32'h200, 1'b1, 1'b1, 5'd1, 25'h1, 32'h200, 1'b1, 2'b11);
        v[3]  = mk(32'h84, 32'h200, 1'b1, 1'b1, 5'd1, 25'h1, 32'h200, 1'b1, 2'b11);
        v[4]  = mk(32'h84, 32'h200, 1'b0, 1'b1, 5'd1, 25'h1, 32'h200, 1'b1, 2'b10);
        v[5]  = mk(32'h84, 32'h200, 1'b0, 1'b1, 5'd1, 25'h1, 32'h200, 1'b1, 2'b01);
        v[6]  = mk(32'h84, 32'h200, 1'b0, 1'b1, 5'd1, 25'h1, 32'h200, 1'b1, 2'b00);
        v[7]  = mk(32'h84, 32'h200, 1'b0, 1'b1, 5'd1, 25'h1, 32'h200, 1'b1, 2'b00);
        v[8]  = mk(32'h1000, 32'h0, 1'b0, 1'b0, 5'd0, 25'h0, 32'h0, 1'b0, 2'b00);
        v[9]  = mk(32'h1084, 32'h300, 1'b1, 1'b1, 5'd1, 25'h21, 32'h300, 1'b1, 2'b10);
        v[10] = mk(32'h1084, 32'h300, 1'b0, 1'b1, 5'd1, 25'h21, 32'h300, 1'b1, 2'b01);
        v[11] = mk(32'h84, 32'h204, 1'b1, 1'b1, 5'd1, 25'h1, 32'h204, 1'b1, 2'b10);
        v[12] = mk(32'hFFFF_FFFC, 32'h40, 1'b1, 1'b1, 5'd31, 25'h1FF_FFFF, 32'h40, 1'b1, 2'b10);
        v[13] = mk(32'hFFFF_FFFC, 32'h44, 1'b0, 1'b1, 5'd31, 25'h1FF_FFFF, 32'h44, 1'b1, 2'b01);

        rst = 1'b1; clr = 1'b1;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; clr = 1'b0;

        chk("rst_load", 64'(btb_load), 64'(0));
        chk("rst_ready", 64'(upd_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rindex", 64'(btb_rindex), 64'(0));
        chk("rst_windex", 64'(btb_windex), 64'(0));
        chk("rst_din", 64'({tag_din, target_din, valid_din, cnt_din}), 64'(0));

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'(0));
            chk("idle_ready", 64'(upd_ready), 64'(1));
            upd_valid = 1'b1; upd_pc = v[i].pc; upd_target = v[i].tgt; upd_taken = v[i].tk;
            @(negedge clk);
            upd_valid = 1'b0;
            chk("rd_load", 64'(btb_load), 64'(0));
            chk("rd_busy", 64'(busy), 64'(1));
            chk("rd_rindex", 64'(btb_rindex), 64'(v[i].wi));
            @(negedge clk);
            chk("wr_load", 64'(btb_load), 64'(v[i].ld));
            chk("wr_busy", 64'(busy), 64'(1));
            chk("wr_windex", 64'(btb_windex), 64'(v[i].wi));
            chk("wr_rindex", 64'(btb_rindex), 64'(v[i].wi));
            chk("wr_tag", 64'(tag_din), 64'(v[i].tag));
            chk("wr_target", 64'(target_din), 64'(v[i].etgt));
            chk("wr_valid", 64'(valid_din), 64'(v[i].vld));
            chk("wr_cnt", 64'(cnt_din), 64'(v[i].cnt));
        end
        @(negedge clk);
        chk("end_busy", 64'(busy), 64'(0));

        // Backpressure: offer a new distinct record every cycle for 10 cycles.
        rst = 1'b1; clr = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; clr = 1'b0;
        exp_q.delete();
        wr_cnt = 0; acc = 0; first_low = -1; kk = 0;
        prev_ld = 1'b0;
        mon_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            upd_valid  = 1'b1;
            upd_pc     = 32'h100 + 32'(4 * kk);
            upd_target = 32'h8000 + 32'(kk);
            upd_taken  = 1'b1;
            if (upd_ready) begin
                exp_q.push_back('{wi: BE'(kk), tag: TW'(2), tgt: 32'h8000 + 32'(kk)});
                acc++;
                kk++;
            end else if (first_low < 0) begin
                first_low = acc;
            end
            @(negedge clk);
        end
        upd_valid = 1'b0;
        repeat (12) @(negedge clk);
        mon_en = 1'b0;
        chk("bp_accepted", 64'(acc), 64'(8));
        chk("bp_ready_low_after", 64'(first_low), 64'(6));
        chk("bp_writes", 64'(wr_cnt), 64'(8));
        chk("bp_left", 64'(exp_q.size()), 64'(0));
        chk("bp_busy", 64'(busy), 64'(0));

        // Reset while a write is pending with three records queued.
        rst = 1'b1; clr = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; clr = 1'b0;
        for (int j = 0; j < 4; j++) begin
            upd_valid = 1'b1; upd_pc = 32'h28 + 32'(4 * j);
            upd_target = 32'h500 + 32'(j); upd_taken = 1'b1;
            @(negedge clk);
        end
        upd_valid = 1'b0;
        chk("mr_pre_load", 64'(btb_load), 64'(1));
        chk("mr_pre_windex", 64'(btb_windex), 64'(11));
        rst = 1'b1;
        #1;
        chk("mr_rst_load", 64'(btb_load), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        chk("mr_ready", 64'(upd_ready), 64'(1));
        chk("mr_busy", 64'(busy), 64'(0));
        chk("mr_load", 64'(btb_load), 64'(0));
        nload = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (btb_load) nload++;
        end
        chk("mr_no_writes", 64'(nload), 64'(0));
        chk("mr_first_written", 64'(m_vld[10]), 64'(1));
        chk("mr_second_killed", 64'(m_vld[11]), 64'(0));
        chk("mr_busy_after", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
